arm_multicycle_ctrl: RTL

- Multicycle control FSM that sequences the shared ARM datapath (register file, ALU, PC, instruction register, unified memory) over several cycles per instruction, replacing the single-cycle combinational controller.
- Decodes data-processing, LDR/STR and B.
- Owns the NZCV flags register and the condition-check logic.
- Sits beside the datapath in the processor top; memory is one unified instruction/data port addressed through AdrSrc.

---
 rtl/arm_multicycle_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/arm_multicycle_ctrl.sv
// rtl/arm_multicycle_ctrl.sv - multicycle ARM control FSM with NZCV flags and condition check
// Sequences fetch/decode/execute/memory/writeback over the shared datapath.
module arm_multicycle_ctrl #(
  parameter int NUM_STATES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [3:0]  ALUControl
);

  localparam int SW = $clog2(NUM_STATES);

  localparam logic [SW-1:0] S_FETCH    = SW'(0);
  localparam logic [SW-1:0] S_DECODE   = SW'(1);
  localparam logic [SW-1:0] S_MEMADR   = SW'(2);
  localparam logic [SW-1:0] S_MEMREAD  = SW'(3);
  localparam logic [SW-1:0] S_MEMWB    = SW'(4);
  localparam logic [SW-1:0] S_MEMWRITE = SW'(5);
  localparam logic [SW-1:0] S_EXECR    = SW'(6);
  localparam logic [SW-1:0] S_EXECI    = SW'(7);
  localparam logic [SW-1:0] S_ALUWB    = SW'(8);
  localparam logic [SW-1:0] S_BRANCH   = SW'(9);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_ORR  = 4'b0011;
  localparam logic [3:0] ALU_EOR  = 4'b0100;
  localparam logic [3:0] ALU_PASS = 4'b0101;

  logic [SW-1:0] state_q, state_d;
  logic [3:0]    flags_q, flags_d;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cond;
  logic       cond_ex;
  logic [3:0] dp_alu;
  logic       dp_nowrite;
  logic       is_cmp;
  logic       pc_write_s, ir_write_s, reg_write_s, mem_write_s;
  logic       unused_bits;

  assign op          = Instr[27:26];
  assign funct       = Instr[25:20];
  assign cond        = Instr[31:28];
  assign is_cmp      = (funct[4:1] == 4'b1010);
  assign unused_bits = ^Instr[19:0];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = flags_q[2];
      4'h1: cond_ex = ~flags_q[2];
      4'h2: cond_ex = flags_q[1];
      4'h3: cond_ex = ~flags_q[1];
      4'h4: cond_ex = flags_q[3];
      4'h5: cond_ex = ~flags_q[3];
      4'h6: cond_ex = flags_q[0];
      4'h7: cond_ex = ~flags_q[0];
      4'h8: cond_ex = flags_q[1] & ~flags_q[2];
      4'h9: cond_ex = ~flags_q[1] | flags_q[2];
      4'hA: cond_ex = (flags_q[3] == flags_q[0]);
      4'hB: cond_ex = (flags_q[3] != flags_q[0]);
      4'hC: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'hD: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Unrecognised DP opcodes execute as a harmless ADD with the write suppressed.
  always_comb begin
    dp_alu     = ALU_ADD;
    dp_nowrite = 1'b0;
    case (funct[4:1])
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b0001: dp_alu = ALU_EOR;
      4'b1101: dp_alu = ALU_PASS;
      4'b1010: begin dp_alu = ALU_SUB; dp_nowrite = 1'b1; end
      default: begin dp_alu = ALU_ADD; dp_nowrite = 1'b1; end
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_ex)          state_d = S_FETCH;
        else if (op == 2'b00)  state_d = funct[5] ? S_EXECI : S_EXECR;
        else if (op == 2'b01)  state_d = S_MEMADR;
        else if (op == 2'b10)  state_d = S_BRANCH;
        else                   state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_MEMADR:         state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:        state_d = S_MEMWB;
      default:          state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUControl  = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_EXECR: ALUControl = dp_alu;
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dp_alu;
      end
      S_ALUWB: reg_write_s = ~dp_nowrite;
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        AdrSrc      = 1'b1;
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pc_write_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset so nothing is written while it is held low.
  assign PCWrite  = pc_write_s & reset;
  assign IRWrite  = ir_write_s & reset;
  assign RegWrite = reg_write_s & reset;
  assign MemWrite = mem_write_s & reset;
  assign ImmSrc   = op;
  assign RegSrc   = {op == 2'b01, op == 2'b10};

  // N/Z follow every flag-setting op; C/V only follow the arithmetic ones.
  always_comb begin
    flags_d = flags_q;
    if (((state_q == S_EXECR) || (state_q == S_EXECI)) && (funct[0] || is_cmp)) begin
      flags_d[3:2] = ALUFlags[3:2];
      if ((dp_alu == ALU_ADD) || (dp_alu == ALU_SUB))
        flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

endmodule
